// File: rtl/alu_result_stage_if.sv
// rtl/alu_result_stage_if.sv - handshake and status bundle between ALU units, result stage and writeback
interface alu_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_carry;
    logic             in_overflow;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_negative;
    logic             out_carry;
    logic             out_overflow;

    logic             ovf_sticky;
    logic             clear_sticky;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, in_result, in_carry, in_overflow, out_ready, clear_sticky,
        input  in_ready, out_valid, out_result, out_zero, out_negative,
               out_carry, out_overflow, ovf_sticky, occupancy
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_overflow, out_ready, clear_sticky,
        output in_ready, out_valid, out_result, out_zero, out_negative,
               out_carry, out_overflow, ovf_sticky, occupancy
    );
endinterface

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - registered ALU result stage with flag capture and 2-entry skid FIFO
module alu_result_stage #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_result_stage_if.slave  bus
);
    localparam int EW = WIDTH + 4;

    // Entry layout: {result, zero, negative, carry, overflow}
    logic [EW-1:0] slot [2];
    logic          head;
    logic [1:0]    occ;
    logic          rdy_q;
    logic          sticky_q;

    logic          push;
    logic          pop;
    logic          tail;
    logic [1:0]    occ_next;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head_entry;

    assign push = bus.in_valid && rdy_q;
    assign pop  = (occ != 2'd0) && bus.out_ready;

    // With one entry held the free slot is the one opposite the head.
    assign tail = head ^ occ[0];

    assign entry_in = {bus.in_result,
                       (bus.in_result == '0),
                       bus.in_result[WIDTH-1],
                       bus.in_carry,
                       bus.in_overflow};

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + 2'd1;
        end else if (!push && pop) begin
            occ_next = occ - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot[0]  <= '0;
            slot[1]  <= '0;
            head     <= 1'b0;
            occ      <= 2'd0;
            rdy_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            if (push) begin
                slot[tail] <= entry_in;
            end
            if (pop) begin
                head <= ~head;
            end
            occ   <= occ_next;
            rdy_q <= (occ_next != 2'd2);
            // A new overflow on the same edge as a clear must not be lost.
            if (push && bus.in_overflow) begin
                sticky_q <= 1'b1;
            end else if (bus.clear_sticky) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign head_entry       = slot[head];
    assign bus.out_result   = head_entry[EW-1:4];
    assign bus.out_zero     = head_entry[3];
    assign bus.out_negative = head_entry[2];
    assign bus.out_carry    = head_entry[1];
    assign bus.out_overflow = head_entry[0];
    assign bus.out_valid    = (occ != 2'd0);
    assign bus.in_ready     = rdy_q;
    assign bus.ovf_sticky   = sticky_q;
    assign bus.occupancy    = occ;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage
module tb_alu_result_stage;
    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_result_stage #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             ovf;
    } beat_t;

    beat_t mq[$];
    logic  m_ready  = 1'b0;
    logic  m_sticky = 1'b0;
    int    checks   = 0;
    int    errors   = 0;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of accepted beats, capacity two, ready one edge behind.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mq.delete();
            m_ready  = 1'b0;
            m_sticky = 1'b0;
        end else begin
            bit    do_push;
            bit    do_pop;
            beat_t b;
            do_push = bus.in_valid && m_ready;
            do_pop  = (mq.size() != 0) && bus.out_ready;
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                b.result = bus.in_result;
                b.carry  = bus.in_carry;
                b.ovf    = bus.in_overflow;
                mq.push_back(b);
            end
            if (do_push && bus.in_overflow) m_sticky = 1'b1;
            else if (bus.clear_sticky)      m_sticky = 1'b0;
            m_ready = (mq.size() < 2);
        end
    end

    initial forever begin
        @(negedge clk);
        check("occupancy", 32'(bus.occupancy), 32'(mq.size()));
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
        check("in_ready", 32'(bus.in_ready), 32'(m_ready));
        check("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
        if (mq.size() != 0) begin
            check("out_result", bus.out_result, mq[0].result);
            check("out_zero", 32'(bus.out_zero), 32'(mq[0].result == 0));
            check("out_negative", 32'(bus.out_negative), 32'(mq[0].result[WIDTH-1]));
            check("out_carry", 32'(bus.out_carry), 32'(mq[0].carry));
            check("out_overflow", 32'(bus.out_overflow), 32'(mq[0].ovf));
        end else begin
            check("no_x_idle", 32'($isunknown({bus.out_result, bus.out_zero, bus.out_negative,
                                               bus.out_carry, bus.out_overflow})), 32'd0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic c, input logic o);
        bus.in_valid    = v;
        bus.in_result   = r;
        bus.in_carry    = c;
        bus.in_overflow = o;
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        bus.out_ready    = 1'b0;
        bus.clear_sticky = 1'b0;
        #1;
        check("rst_occupancy", 32'(bus.occupancy), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_flags", 32'({bus.out_zero, bus.out_negative, bus.out_carry, bus.out_overflow}), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_sticky", 32'(bus.ovf_sticky), 32'd0);

        step(2);
        reset_n = 1'b1;
        #1 check("rel_in_ready_low", 32'(bus.in_ready), 32'd0);
        step(1);
        check("rel_in_ready_high", 32'(bus.in_ready), 32'd1);

        // Single NOR(0,0) beat
        drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t1_result", bus.out_result, 32'hFFFF_FFFF);
        check("t1_negative", 32'(bus.out_negative), 32'd1);
        check("t1_zero", 32'(bus.out_zero), 32'd0);
        check("t1_occ1", 32'(bus.occupancy), 32'd1);
        step(1);
        check("t1_occ0", 32'(bus.occupancy), 32'd0);

        // Zero result
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t2_zero", 32'(bus.out_zero), 32'd1);
        check("t2_negative", 32'(bus.out_negative), 32'd0);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        check("t2_drained", 32'(bus.occupancy), 32'd0);

        // Backpressure until full, then drain in order
        drive(1'b1, 32'h0000_0001, 1'b0, 1'b0);
        step(1);
        drive(1'b1, 32'hFFFF_FF6C, 1'b1, 1'b0);
        step(1);
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        check("t3_full_occ", 32'(bus.occupancy), 32'd2);
        check("t3_full_rdy", 32'(bus.in_ready), 32'd0);
        step(3);
        check("t3_hold_head", bus.out_result, 32'h0000_0001);
        check("t3_hold_occ", 32'(bus.occupancy), 32'd2);
        bus.out_ready = 1'b1;
        step(1);
        check("t3_drain2", bus.out_result, 32'hFFFF_FF6C);
        check("t3_rdy_back", 32'(bus.in_ready), 32'd1);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t3_drain3", bus.out_result, 32'h1234_5678);
        check("t3_drain3_occ", 32'(bus.occupancy), 32'd1);
        step(1);
        check("t3_empty", 32'(bus.occupancy), 32'd0);

        // Simultaneous push/pop at occupancy 1
        drive(1'b1, 32'hA, 1'b0, 1'b0);
        step(1);
        check("t4_a", bus.out_result, 32'hA);
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        step(1);
        check("t4_b", bus.out_result, 32'hB);
        check("t4_occ_b", 32'(bus.occupancy), 32'd1);
        drive(1'b1, 32'hC, 1'b0, 1'b0);
        step(1);
        check("t4_c", bus.out_result, 32'hC);
        check("t4_occ_c", 32'(bus.occupancy), 32'd1);
        drive(1'b0, '0, 1'b0, 1'b0);
        step(1);

        // Sticky overflow: set, survive pop, set beats clear, clear alone
        drive(1'b1, 32'h8000_0000, 1'b1, 1'b1);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t5_sticky_set", 32'(bus.ovf_sticky), 32'd1);
        check("t5_out_ovf", 32'(bus.out_overflow), 32'd1);
        check("t5_out_carry", 32'(bus.out_carry), 32'd1);
        step(1);
        check("t5_after_pop", 32'(bus.ovf_sticky), 32'd1);
        drive(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        bus.clear_sticky = 1'b1;
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t5_set_wins", 32'(bus.ovf_sticky), 32'd1);
        step(1);
        bus.clear_sticky = 1'b0;
        check("t5_cleared", 32'(bus.ovf_sticky), 32'd0);
        step(1);

        // Reset mid-operation with two entries held
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(1);
        drive(1'b1, 32'h0BAD_F00D, 1'b0, 1'b0);
        step(1);
        drive(1'b0, '0, 1'b0, 1'b0);
        check("t6_occ2", 32'(bus.occupancy), 32'd2);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.out_valid), 32'd0);
        check("t6_async_occ", 32'(bus.occupancy), 32'd0);
        check("t6_async_sticky", 32'(bus.ovf_sticky), 32'd0);
        check("t6_async_rdy", 32'(bus.in_ready), 32'd0);
        step(2);
        reset_n = 1'b1;
        bus.out_ready = 1'b1;
        step(1);
        check("t6_rdy_after", 32'(bus.in_ready), 32'd1);
        step(3);
        check("t6_no_stale", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 32-bit ALU function units (NOR, AND, OR, ADD/SUB, etc.).
- Captures each ALU result beat and derives zero/negative flags at capture.
- Forwards carry/overflow from the adder path and keeps a sticky overflow status bit.
- Buffers results in a 2-entry skid FIFO with valid/ready on both sides, so a stalled writeback consumer never drops an ALU result.

Parameters:
- WIDTH, 32, datapath width of result bus.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  ALU result beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_result  in  WIDTH  ALU result (e.g. NOR output).
- in_carry  in  1  carry-out from adder path; 0 for logic ops.
- in_overflow  in  1  signed overflow from adder path; 0 for logic ops.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts head entry.
- out_result  out  WIDTH  head entry result.
- out_zero  out  1  head result == 0.
- out_negative  out  1  head result[WIDTH-1].
- out_carry  out  1  head carry.
- out_overflow  out  1  head overflow.
- ovf_sticky  out  1  set by any accepted beat with overflow.
- clear_sticky  in  1  synchronous clear of ovf_sticky.
- occupancy  out  2  entries held, 0..2.

Behaviour:
- Reset (reset_n low, async):
  - occupancy=0, out_valid=0.
  - out_result=0, all out_* flags=0.
  - ovf_sticky=0.
  - in_ready=0.
- First rising edge after reset_n deasserts: in_ready becomes 1. No beat is accepted before then.
- in_ready is registered: in_ready = (next occupancy < 2). It never depends combinationally on in_valid or out_ready.
- Push happens when in_valid && in_ready at a rising edge. Pop happens when out_valid && out_ready at a rising edge.
- Flags are computed at push time and stored with the entry:
  - zero = (in_result == 0).
  - negative = in_result[WIDTH-1].
  - carry and overflow are copied from the inputs.
- Latency: a beat pushed into an empty stage at edge N is visible on out_* with out_valid=1 after edge N. There is no combinational in->out path.
- Ordering is strict FIFO. out_* always presents the oldest entry.
- Head stability: while out_valid && !out_ready, out_result and all out flags hold constant.
- out_valid = (occupancy != 0). out_* values when out_valid=0 are don't-care but must not be X after reset.
- Occupancy transitions:
  - 0: push -> 1.
  - 1: push only -> 2; pop only -> 0; push+pop -> 1, with the new beat becoming head on the next cycle.
  - 2: in_ready=0, so push is impossible. Pop -> 1 and in_ready returns to 1 the following cycle.
- Entry storage is two slots with a head pointer that toggles on pop; no data shifting. Pointer wrap is modulo 2.
- Sticky overflow:
  - Set on an accepted push with in_overflow=1.
  - clear_sticky=1 clears it at the edge.
  - If set and clear occur on the same edge, set wins (ovf_sticky=1).
  - Unaffected by pops.
- Reset mid-operation: all entries are discarded immediately (out_valid falls asynchronously). Behaviour then proceeds as from power-on reset.
- in_valid while in_ready=0 is not a protocol error. The beat is simply not taken, and the upstream must hold it.

Test Plan:
- Reset then single beat: release reset_n; cycle 1 in_ready=1; push in_result=0xFFFFFFFF (NOR of 0,0), out_ready=1 -> next cycle out_result=0xFFFFFFFF, negative=1, zero=0, carry=0, overflow=0, occupancy=1 then 0.
- Zero flag: push in_result=0x00000000 (NOR of 0xFFFFFFFF,0) -> out_zero=1, out_negative=0.
- Backpressure/full: out_ready=0, push 0x00000001 then 0xFFFFFF6C -> occupancy=2, in_ready=0; hold in_valid with 0x12345678 for 3 cycles -> not accepted, out_result stays 0x00000001; raise out_ready -> drains 0x00000001, 0xFFFFFF6C, then 0x12345678 in order.
- Simultaneous push/pop at occupancy 1: continuous in_valid/out_ready with results 0xA, 0xB, 0xC -> occupancy stays 1, outputs 0xA, 0xB, 0xC on consecutive cycles with no bubble.
- Sticky overflow: push with in_overflow=1 -> ovf_sticky=1 and persists after pop. Assert clear_sticky on the same edge as another overflow push -> ovf_sticky stays 1. clear_sticky alone -> 0.
- Reset mid-operation: occupancy=2, assert reset_n=0 between edges -> out_valid=0, occupancy=0, ovf_sticky=0 immediately; after release, in_ready=1 one cycle later and no stale entries appear.
